// File: rtl/nes_bus_arbiter.sv
// Shares the CPU-side system bus between the 6502 and NUM_MST DMA masters, with read decode and open-bus latch.
// Build option: define ARB_RR_EN for round-robin arbitration; fixed priority (lowest index wins) otherwise.
module nes_bus_arbiter #(
  parameter int NUM_MST = 2,
  parameter int AW      = 16,
  parameter int DW      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic [AW-1:0]         i_cpu_addr,
  input  logic                  i_cpu_r_wn,
  input  logic [DW-1:0]         i_cpu_wdata,
  output logic [DW-1:0]         o_cpu_rdata,
  output logic                  o_cpu_pause,
  input  logic [NUM_MST-1:0]    i_mst_req,
  input  logic [NUM_MST*AW-1:0] i_mst_addr,
  input  logic [NUM_MST-1:0]    i_mst_wn,
  input  logic [NUM_MST*DW-1:0] i_mst_wdata,
  output logic [NUM_MST-1:0]    o_mst_gnt,
  output logic [DW-1:0]         o_mst_rdata,
  output logic [AW-1:0]         o_bus_addr,
  output logic [DW-1:0]         o_bus_wdata,
  output logic                  o_bus_wn,
  input  logic [DW-1:0]         i_ram_rdata,
  input  logic [DW-1:0]         i_ppu_rdata,
  input  logic [DW-1:0]         i_apu_rdata,
  input  logic [DW-1:0]         i_jpd_rdata,
  input  logic [DW-1:0]         i_mmc_rdata
);

  localparam int OW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic [1:0] {S_CPU, S_HALT, S_DMA} state_e;

  state_e        state_q;
  logic [OW-1:0] owner_q;
  logic          pause_q;
  logic [DW-1:0] openBus_q, openBus_d;
`ifdef ARB_RR_EN
  logic [OW-1:0] lastOwner_q;
`endif

  logic [AW-1:0] mstAddr  [NUM_MST];
  logic [DW-1:0] mstWdata [NUM_MST];
  logic [AW-1:0] busAddr;
  logic [DW-1:0] busWdata;
  logic          busWn;
  logic          transfer;
  logic [DW-1:0] rdata;
  logic [OW-1:0] winner;
  logic          anyReq;

  for (genvar k = 0; k < NUM_MST; k++) begin : g_unpack
    assign mstAddr[k]  = i_mst_addr[k*AW +: AW];
    assign mstWdata[k] = i_mst_wdata[k*DW +: DW];
  end

  assign anyReq = |i_mst_req;

  // Bus owner mux; the turnaround and ungranted DMA cycles park the bus on a harmless read of 0x0000.
  always_comb begin
    busAddr  = '0;
    busWn    = 1'b1;
    busWdata = '0;
    transfer = 1'b0;
    unique case (state_q)
      S_CPU: begin
        busAddr  = i_cpu_addr;
        busWn    = i_cpu_r_wn;
        busWdata = i_cpu_wdata;
        transfer = 1'b1;
      end
      S_DMA: begin
        if (i_mst_req[owner_q]) begin
          busAddr  = mstAddr[owner_q];
          busWn    = i_mst_wn[owner_q];
          busWdata = mstWdata[owner_q];
          transfer = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    o_mst_gnt = '0;
    if (state_q == S_DMA) o_mst_gnt[owner_q] = i_mst_req[owner_q];
  end

  // Joypad is tested before the APU range because 0x4016/0x4017 sit inside the APU window.
  always_comb begin
    if (busAddr < AW'(16'h2000))                                  rdata = i_ram_rdata;
    else if (busAddr < AW'(16'h4000))                             rdata = i_ppu_rdata;
    else if (busAddr == AW'(16'h4016) || busAddr == AW'(16'h4017)) rdata = i_jpd_rdata;
    else if (busAddr < AW'(16'h4016))                             rdata = i_apu_rdata;
    else if (busAddr < AW'(16'h4020))                             rdata = openBus_q;
    else                                                          rdata = i_mmc_rdata;
  end

  always_comb begin
    openBus_d = openBus_q;
    if (transfer) openBus_d = busWn ? rdata : busWdata;
  end

  // Later loop iterations override earlier ones, so the highest-priority requester is visited last.
`ifdef ARB_RR_EN
  int candSum;
  always_comb begin
    winner  = '0;
    candSum = 0;
    for (int i = NUM_MST; i >= 1; i--) begin
      candSum = int'(lastOwner_q) + i;
      if (candSum >= NUM_MST) candSum = candSum - NUM_MST;
      if (i_mst_req[OW'(candSum)]) winner = OW'(candSum);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_MST - 1; i >= 0; i--) begin
      if (i_mst_req[i]) winner = OW'(i);
    end
  end
`endif

  // Reads only may be stolen, since the 6502 cannot stall mid-write.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_CPU;
      owner_q     <= '0;
      pause_q     <= 1'b0;
      openBus_q   <= '0;
`ifdef ARB_RR_EN
      lastOwner_q <= OW'(NUM_MST - 1);
`endif
    end else begin
      openBus_q <= openBus_d;
      unique case (state_q)
        S_CPU: begin
          if (anyReq && i_cpu_r_wn) begin
            state_q <= S_HALT;
            pause_q <= 1'b1;
          end
        end
        S_HALT: begin
          if (anyReq) begin
            state_q     <= S_DMA;
            owner_q     <= winner;
`ifdef ARB_RR_EN
            lastOwner_q <= winner;
`endif
          end else begin
            state_q <= S_CPU;
            pause_q <= 1'b0;
          end
        end
        S_DMA: begin
          if (!i_mst_req[owner_q]) begin
            if (anyReq) begin
              state_q <= S_HALT;
            end else begin
              state_q <= S_CPU;
              pause_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_CPU;
          pause_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_pause = pause_q;
  assign o_cpu_rdata = rdata;
  assign o_mst_rdata = rdata;
  assign o_bus_addr  = busAddr;
  assign o_bus_wdata = busWdata;
  assign o_bus_wn    = busWn;

endmodule

// File: tb/tb_nes_bus_arbiter.sv
// Self-checking bench for nes_bus_arbiter: directed scenarios plus randomized traffic against a bus-ownership model.
// Honours ARB_RR_EN the same way as the design.
module tb_nes_bus_arbiter;

  localparam int NUM_MST = 2;
  localparam int AW      = 16;
  localparam int DW      = 8;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [AW-1:0]         cpuAddr;
  logic                  cpuRwn;
  logic [DW-1:0]         cpuWdata;
  logic [DW-1:0]         cpuRdata;
  logic                  cpuPause;
  logic [NUM_MST-1:0]    mstReq;
  logic [NUM_MST*AW-1:0] mstAddr;
  logic [NUM_MST-1:0]    mstWn;
  logic [NUM_MST*DW-1:0] mstWdata;
  logic [NUM_MST-1:0]    mstGnt;
  logic [DW-1:0]         mstRdata;
  logic [AW-1:0]         busAddr;
  logic [DW-1:0]         busWdata;
  logic                  busWn;
  logic [DW-1:0]         ramData, ppuData, apuData, jpdData, mmcData;

  int compared   = 0;
  int mismatched = 0;

  // Model: who holds the bus (-1 = CPU, -2 = dummy-read turnaround, k = master k), open-bus byte, last winner.
  int          mdlHolder;
  logic [7:0]  mdlOpenBus;
  int          mdlLast;

  always #5 clk = ~clk;

  nes_bus_arbiter #(.NUM_MST(NUM_MST), .AW(AW), .DW(DW)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cpu_addr  (cpuAddr),
    .i_cpu_r_wn  (cpuRwn),
    .i_cpu_wdata (cpuWdata),
    .o_cpu_rdata (cpuRdata),
    .o_cpu_pause (cpuPause),
    .i_mst_req   (mstReq),
    .i_mst_addr  (mstAddr),
    .i_mst_wn    (mstWn),
    .i_mst_wdata (mstWdata),
    .o_mst_gnt   (mstGnt),
    .o_mst_rdata (mstRdata),
    .o_bus_addr  (busAddr),
    .o_bus_wdata (busWdata),
    .o_bus_wn    (busWn),
    .i_ram_rdata (ramData),
    .i_ppu_rdata (ppuData),
    .i_apu_rdata (apuData),
    .i_jpd_rdata (jpdData),
    .i_mmc_rdata (mmcData)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] mdlRead(input logic [15:0] a);
    if (a <= 16'h1FFF) return ramData;
    if (a <= 16'h3FFF) return ppuData;
    if (a == 16'h4016 || a == 16'h4017) return jpdData;
    if (a <= 16'h4015) return apuData;
    if (a <= 16'h401F) return mdlOpenBus;
    return mmcData;
  endfunction

  function automatic int mdlPick(input logic [NUM_MST-1:0] req);
`ifdef ARB_RR_EN
    for (int k = 1; k <= NUM_MST; k++) begin
      int c;
      c = (mdlLast + k) % NUM_MST;
      if (req[c]) return c;
    end
`else
    for (int c = 0; c < NUM_MST; c++) begin
      if (req[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic mdlReset();
    mdlHolder  = -1;
    mdlOpenBus = 8'h00;
    mdlLast    = NUM_MST - 1;
  endtask

  // Called just after a falling edge with inputs driven: compares every output with the model, then advances the model.
  task automatic applyStimulus();
    logic [15:0]        eAddr;
    logic               eWn;
    logic [7:0]         eWdata;
    logic [7:0]         eData;
    logic [NUM_MST-1:0] eGnt;
    logic               xfer;
    int                 pick;
    #1;
    eGnt = '0;
    xfer = 1'b0;
    eAddr = 16'h0000;
    eWn = 1'b1;
    eWdata = 8'h00;
    if (mdlHolder == -1) begin
      eAddr = cpuAddr; eWn = cpuRwn; eWdata = cpuWdata; xfer = 1'b1;
    end else if (mdlHolder >= 0 && mstReq[mdlHolder]) begin
      eGnt[mdlHolder] = 1'b1;
      eAddr  = mstAddr[mdlHolder*AW +: AW];
      eWn    = mstWn[mdlHolder];
      eWdata = mstWdata[mdlHolder*DW +: DW];
      xfer   = 1'b1;
    end
    eData = mdlRead(eAddr);
    checkOutput("pause",     cpuPause, mdlHolder != -1);
    checkOutput("gnt",       mstGnt,   eGnt);
    checkOutput("bus_addr",  busAddr,  eAddr);
    checkOutput("bus_wn",    busWn,    eWn);
    checkOutput("cpu_rdata", cpuRdata, eData);
    checkOutput("mst_rdata", mstRdata, eData);
    if (xfer && !eWn) checkOutput("bus_wdata", busWdata, eWdata);
    if (xfer) mdlOpenBus = eWn ? eData : eWdata;
    if (mdlHolder == -1) begin
      if (mstReq != '0 && cpuRwn) mdlHolder = -2;
    end else if (mdlHolder == -2) begin
      pick = mdlPick(mstReq);
      if (pick >= 0) mdlLast = pick;
      mdlHolder = pick;
    end else if (!mstReq[mdlHolder]) begin
      mdlHolder = (mstReq != '0) ? -2 : -1;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    applyStimulus();
    nextCycle();
  endtask

  task automatic cpuRead(input logic [15:0] a);
    cpuAddr = a; cpuRwn = 1'b1;
  endtask

  function automatic logic [15:0] randAddr();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(0, 16'h1FFF));
      1:       return 16'($urandom_range(16'h2000, 16'h3FFF));
      2:       return 16'($urandom_range(16'h4016, 16'h4017));
      3:       return 16'($urandom_range(16'h4000, 16'h4015));
      4:       return 16'($urandom_range(16'h4018, 16'h401F));
      default: return 16'($urandom_range(16'h4020, 16'hFFFF));
    endcase
  endfunction

  task automatic randomizeInputs();
    cpuAddr  = randAddr();
    cpuRwn   = ($urandom_range(0, 3) != 0);
    cpuWdata = 8'($urandom);
    ramData  = 8'($urandom);
    ppuData  = 8'($urandom);
    apuData  = 8'($urandom);
    jpdData  = 8'($urandom);
    mmcData  = 8'($urandom);
    for (int k = 0; k < NUM_MST; k++) begin
      if (mstReq[k]) mstReq[k] = ($urandom_range(0, 7) != 0);
      else           mstReq[k] = ($urandom_range(0, 9) == 0);
      mstAddr[k*AW +: AW]  = randAddr();
      mstWn[k]             = $urandom_range(0, 1) != 0;
      mstWdata[k*DW +: DW] = 8'($urandom);
    end
  endtask

  initial begin
    rstn = 1'b0;
    cpuAddr = 16'h1234; cpuRwn = 1'b1; cpuWdata = 8'h00;
    mstReq = '0; mstAddr = '0; mstWn = '1; mstWdata = '0;
    ramData = 8'h00; ppuData = 8'h00; apuData = 8'h00; jpdData = 8'h00; mmcData = 8'h00;
    mdlReset();
    #2;
    checkOutput("rst_pause",    cpuPause, 1'b0);
    checkOutput("rst_gnt",      mstGnt,   2'b00);
    checkOutput("rst_bus_addr", busAddr,  16'h1234);
    @(negedge clk);
    rstn = 1'b1;

    cpuRead(16'h0005); ramData = 8'h3C;
    applyStimulus();
    checkOutput("ram_read", cpuRdata, 8'h3C);
    nextCycle();

    // Master 1 requests during a CPU write: the steal waits for the following read.
    cpuAddr = 16'h2006; cpuRwn = 1'b0; cpuWdata = 8'h11;
    mstReq = 2'b10; mstAddr[AW +: AW] = 16'h0200; mstWn = 2'b11;
    applyStimulus();
    checkOutput("wr_no_pause", cpuPause, 1'b0);
    nextCycle();
    cpuRead(16'h2002); ppuData = 8'h77;
    step();
    applyStimulus();
    checkOutput("halt_pause", cpuPause, 1'b1);
    checkOutput("halt_addr",  busAddr,  16'h0000);
    checkOutput("halt_wn",    busWn,    1'b1);
    checkOutput("halt_gnt",   mstGnt,   2'b00);
    nextCycle();
    for (int i = 0; i < 256; i++) begin
      mstAddr[AW +: AW] = 16'h0200 + 16'(i);
      ramData = 8'($urandom);
      applyStimulus();
      checkOutput("burst_gnt",  mstGnt,  2'b10);
      checkOutput("burst_addr", busAddr, 16'h0200 + 16'(i));
      nextCycle();
    end
    mstReq = 2'b00;
    applyStimulus();
    checkOutput("drop_pause", cpuPause, 1'b1);
    nextCycle();
    applyStimulus();
    checkOutput("released_pause", cpuPause, 1'b0);
    nextCycle();

    // Simultaneous requests: master 0 first, master 1 after a turnaround cycle.
    mstReq = 2'b11; mstAddr = {16'h0400, 16'h0300};
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("both_gnt0", mstGnt, 2'b01);
      nextCycle();
    end
    mstReq = 2'b10;
    applyStimulus();
    checkOutput("turn_idle_gnt", mstGnt, 2'b00);
    nextCycle();
    applyStimulus();
    checkOutput("turn_halt_gnt", mstGnt, 2'b00);
    nextCycle();
    applyStimulus();
    checkOutput("turn_gnt1", mstGnt, 2'b10);
    nextCycle();
    mstReq = 2'b00;
    step();

    // Master 0 alone, then both together: round-robin now favours master 1.
    mstReq = 2'b01;
    step(); step(); step();
    mstReq = 2'b00;
    step();
    mstReq = 2'b11;
    step(); step();
    applyStimulus();
`ifdef ARB_RR_EN
    checkOutput("after0_gnt", mstGnt, 2'b10);
`else
    checkOutput("after0_gnt", mstGnt, 2'b01);
`endif
    nextCycle();
    mstReq = 2'b00;
    step(); step();

    cpuAddr = 16'h0300; cpuRwn = 1'b0; cpuWdata = 8'hA5;
    step();
    cpuRead(16'h4018);
    applyStimulus();
    checkOutput("open_bus", cpuRdata, 8'hA5);
    nextCycle();

    // Reset dropped while master 0 owns the bus.
    mstReq = 2'b01; mstAddr[0 +: AW] = 16'h0010; mstWn = 2'b11; ramData = 8'h5A;
    step(); step();
    applyStimulus();
    checkOutput("pre_rst_gnt", mstGnt, 2'b01);
    rstn = 1'b0;
    #1;
    checkOutput("async_rst_gnt",   mstGnt,   2'b00);
    checkOutput("async_rst_pause", cpuPause, 1'b0);
    mdlReset();
    nextCycle();
    mstReq = 2'b00;
    rstn = 1'b1;
    cpuRead(16'h401B);
    applyStimulus();
    checkOutput("rst_open_bus", cpuRdata, 8'h00);
    nextCycle();
    cpuRead(16'h0001); ramData = 8'h42;
    step();

    mstReq = '0;
    for (int n = 0; n < 3000; n++) begin
      randomizeInputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
